// File: rtl/encoder8_3_evt.sv
// encoder8_3_evt : rising-edge event encoder with output FIFO.
//
// Watches 8 level inputs (already synchronised/debounced), turns each rising
// edge into a 3-bit index and queues the indices for a valid/ready consumer.
// At most one index is queued per cycle; edges that cannot be queued yet wait
// in a per-lane pending bit and are granted later by priority.
//
// Build option:
//   ENC_LSB_PRIORITY_EN  defined   -> lowest pending index is queued first
//                        undefined -> highest pending index is queued first
//
// Ports:
//   sys_clk    in   1         clock, everything on the rising edge
//   sys_rst    in   1         synchronous active-high reset
//   in         in   8         level inputs
//   out        out  3         code at FIFO head (meaningful while out_valid)
//   out_valid  out  1         FIFO not empty
//   out_ready  in   1         consumer takes the head code
//   fifo_cnt   out  ADDR_W+1  entries held, 0..FIFO_DEPTH
//   ovf        out  1         sticky: two edges on one lane merged into one

// Per-lane edge detector and pending bit.
//   cand  : lane has an event waiting (old pending or fresh rise)
//   merge : fresh rise while an older event is still pending on this lane
module encoder8_3_evt_lane (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic in_bit,
  input  logic take,
  output logic cand,
  output logic merge
);
  logic in_d;
  logic pend;
  logic rise;

  assign rise  = in_bit & ~in_d;
  assign cand  = pend | rise;
  assign merge = pend & rise;

  // in_d follows in during reset too, so levels held high across reset
  // never look like an edge.
  always_ff @(posedge sys_clk) begin
    in_d <= in_bit;
    if (sys_rst) pend <= 1'b0;
    else         pend <= cand & ~take;
  end
endmodule

module encoder8_3_evt #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        in,
  output logic [2:0]        out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              ovf
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  logic [7:0]        cand;
  logic [7:0]        merge;
  logic [7:0]        grant;
  logic [7:0]        take;
  logic [2:0]        code;
  logic              push;
  logic              pop;
  logic              full;
  logic [2:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [2:0]        last_out;

  assign take = grant & {8{push}};

  encoder8_3_evt_lane u_lane [7:0] (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in_bit  (in),
    .take    (take),
    .cand    (cand),
    .merge   (merge)
  );

  // Priority select: the last match in scan order wins.
  always_comb begin
    code = 3'd0;
`ifdef ENC_LSB_PRIORITY_EN
    for (int i = 7; i >= 0; i--)
      if (cand[i]) code = 3'(i);
`else
    for (int i = 0; i < 8; i++)
      if (cand[i]) code = 3'(i);
`endif
  end

  assign grant = (|cand) ? (8'd1 << code) : 8'd0;

  assign full      = (fifo_cnt == DEPTH_C);
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  // When full, a pop frees the head slot this same edge, so the push can
  // overwrite it (wr_ptr == rd_ptr) while the head is being read.
  assign push      = (|cand) & (~full | pop);

  // While empty, keep showing whatever was last presented.
  assign out = out_valid ? mem[rd_ptr] : last_out;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push) mem[wr_ptr] <= code;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
      last_out <= 3'd0;
    end else begin
      last_out <= out;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (|merge) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_encoder8_3_evt.sv
module tb_encoder8_3_evt;
  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] din;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_cnt;
  logic       ovf;

  int nchk = 0;
  int nerr = 0;

  // model state: queue of codes, pending set, previous input, sticky flag
  int       mq[$];
  bit [7:0] mpend;
  bit [7:0] mprev;
  bit       movf;
  int       got[$];

  encoder8_3_evt #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in        (din),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Priority pick straight from the rule: which waiting index goes first.
  function automatic int pick(input bit [7:0] c);
    int idx = -1;
`ifdef ENC_LSB_PRIORITY_EN
    for (int b = 0; b < 8; b++) if (c[b] && idx < 0) idx = b;
`else
    for (int b = 7; b >= 0; b--) if (c[b] && idx < 0) idx = b;
`endif
    return idx;
  endfunction

  task automatic model_edge();
    bit [7:0] rise, c;
    bit pop, full;
    int idx;
    if (sys_rst) begin
      mq.delete();
      mpend = '0;
      movf  = 1'b0;
      mprev = din;
      return;
    end
    rise  = din & ~mprev;
    mprev = din;
    pop   = (mq.size() > 0) && out_ready;
    full  = (mq.size() == DEPTH);
    if ((rise & mpend) != 0) movf = 1'b1;
    c = mpend | rise;
    if (pop) void'(mq.pop_front());
    if (c != 0 && (!full || pop)) begin
      idx = pick(c);
      mq.push_back(idx);
      c[idx] = 1'b0;
    end
    mpend = c;
  endtask

  task automatic compare();
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("fifo_cnt", int'(fifo_cnt), mq.size());
    chk("ovf", int'(ovf), int'(movf));
    if (mq.size() != 0) chk("out", int'(out), mq[0]);
  endtask

  // One clock: note what the consumer takes, clock, update model, compare.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      if (out_valid && out_ready && !sys_rst) got.push_back(int'(out));
      @(posedge sys_clk);
      model_edge();
      @(negedge sys_clk);
      compare();
    end
  endtask

  task automatic expect_seq(input string nm, input int e[$]);
    chk({nm, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(nm, got[i], e[i]);
    got.delete();
  endtask

  initial begin
    sys_rst   = 1'b1;
    din       = 8'h81;
    out_ready = 1'b0;
    cyc(2);
    chk("rst_out", int'(out), 0);
    chk("rst_cnt", int'(fifo_cnt), 0);

    // levels high through reset: no events
    sys_rst   = 1'b0;
    out_ready = 1'b1;
    cyc(10);
    chk("held_valid", int'(out_valid), 0);
    chk("held_ovf", int'(ovf), 0);

    // single edge, consumer ready
    din = 8'h00; cyc(2);
    din = 8'h20; cyc();
    chk("b5_out", int'(out), 5);
    chk("b5_valid", int'(out_valid), 1);
    chk("b5_cnt1", int'(fifo_cnt), 1);
    cyc();
    chk("b5_cnt0", int'(fifo_cnt), 0);
    chk("b5_valid0", int'(out_valid), 0);
    expect_seq("b5_seq", '{5});

    // two simultaneous edges
    out_ready = 1'b0; din = 8'h00; cyc();
    din = 8'h0A; cyc(2);
    chk("0a_cnt", int'(fifo_cnt), 2);
    out_ready = 1'b1; cyc(3);
    chk("0a_valid0", int'(out_valid), 0);
`ifdef ENC_LSB_PRIORITY_EN
    expect_seq("0a_seq", '{1, 3});
`else
    expect_seq("0a_seq", '{3, 1});
`endif

    // fill, then two more edges wait while full
    out_ready = 1'b0; din = 8'h00; cyc(2);
    din = 8'h01; cyc();
    din = 8'h03; cyc();
    din = 8'h07; cyc();
    din = 8'h0F; cyc();
    chk("full_cnt", int'(fifo_cnt), 4);
    din = 8'h3F; cyc(2);
    chk("full_cnt2", int'(fifo_cnt), 4);
    chk("full_ovf", int'(ovf), 0);
    out_ready = 1'b1; cyc(8);
`ifdef ENC_LSB_PRIORITY_EN
    expect_seq("full_seq", '{0, 1, 2, 3, 4, 5});
`else
    expect_seq("full_seq", '{0, 1, 2, 3, 5, 4});
`endif

    // merge on lane 6 while it is still pending
    out_ready = 1'b0; din = 8'h00; cyc(2);
    din = 8'h01; cyc();
    din = 8'h03; cyc();
    din = 8'h07; cyc();
    din = 8'h0F; cyc();
    din = 8'h4F; cyc();
    chk("mrg_ovf0", int'(ovf), 0);
    din = 8'h0F; cyc();
    din = 8'h4F; cyc();
    chk("mrg_ovf1", int'(ovf), 1);
    cyc(2);
    out_ready = 1'b1; cyc(8);
    chk("mrg_ovf_sticky", int'(ovf), 1);
    expect_seq("mrg_seq", '{0, 1, 2, 3, 6});

    // reset mid-operation with queued and pending data
    out_ready = 1'b0; din = 8'h00; cyc(2);
    din = 8'h01; cyc();
    din = 8'h03; cyc();
    din = 8'hE3; cyc();
    chk("mid_cnt3", int'(fifo_cnt), 3);
    sys_rst = 1'b1; cyc();
    sys_rst = 1'b0;
    chk("mid_cnt0", int'(fifo_cnt), 0);
    chk("mid_valid0", int'(out_valid), 0);
    chk("mid_ovf0", int'(ovf), 0);
    got.delete();
    out_ready = 1'b1; cyc(6);
    chk("mid_valid_after", int'(out_valid), 0);
    expect_seq("mid_seq", '{});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
